tank_damage_ctrl: RTL and testbench
===================================

Name: tank_damage_ctrl

Overview:
Receiving end of the gun/hit path. Consumes hit reports and opponent bullet coordinates aimed at our tank, then maintains tank health, enforces a post-hit invulnerability window and declares death. It also overlays a health bar and a hit-flash on the VGA pixel stream, and sits in the VGA chain directly after the gun stage.

Parameters:
HP_MAX, 100, health after reset/restart (7-bit range, 1..127)
DAMAGE, 20, HP removed per accepted hit
INVULN_CYCLES, 65000000, cooldown length in clk cycles after an accepted hit
FLASH_BIT, 22, cooldown-counter bit that gates the flash overlay (flash while bit = 1)
BAR_X, 10, health bar left x; BAR_Y, 10, top y; bar height 8 px
TANK_SIZE, 48, tank hitbox edge in px
FLASH_COLOR, 12'hF00, overlay on tank box during cooldown; DEAD_COLOR, 12'h444, tank box when dead; BAR_COLOR, 12'h0F0

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
restart  in  1  level; return to full health (synchronous)
hit_in  in  1  hit report from opponent gun; rising edge = one hit
xpos_bullet_op, ypos_bullet_op  in  10 each  opponent bullet position; (0,0) = no bullet
xpos_t, ypos_t  in  10 each  our tank top-left
hblnk, vblnk, hsync, vsync  in  1 each  VGA timing
hcount  in  11; vcount  in  10; rgb  in  12  pixel stream
hblnk_out, vblnk_out, hsync_out, vsync_out, hcount_out, vcount_out, rgb_out  out  same widths  delayed stream
hp  out  7  current health
dead  out  1  high in DEAD
hit_ack  out  1  one-cycle pulse per accepted hit
invuln  out  1  high during cooldown

Behaviour:
- Reset: state ALIVE, hp = HP_MAX, hit_in_q = 0, counter = 0. All timing/count/rgb outputs are 0; dead, hit_ack, invuln = 0.
- Timing, hcount, vcount and rgb pass with exactly 1 cycle latency. rgb_out is computed from same-cycle inputs and registered.
- hit_evt = (hit_in & ~hit_in_q) OR bullet_overlap (feature only). hit_in_q is registered every cycle.
- bullet_overlap: bullet ≠ (0,0), xpos_t ≤ xb ≤ xpos_t+TANK_SIZE-1, and ypos_t ≤ yb ≤ ypos_t+TANK_SIZE-1. Compare in 11 bits; no wrap.
- States:
  - ALIVE: on hit_evt go to HIT.
  - HIT (1 cycle):
    - hit_ack = 1.
    - hp_nxt = (hp ≤ DAMAGE) ? 0 : hp − DAMAGE.
    - If hp_nxt == 0, go to DEAD; otherwise counter = 0 and go to INVULN.
  - INVULN:
    - invuln = 1; counter increments each cycle.
    - When counter == INVULN_CYCLES−1, go to ALIVE.
    - hit_evt is ignored (dropped, not queued).
  - DEAD: dead = 1; sticky. hit_evt is ignored.
- Latency: hit_in first sampled high at edge N → HIT during cycle N+1 → hp/dead/invuln updated at edge N+2.
- restart = 1 in any state: next state ALIVE, hp = HP_MAX, counter = 0, hit_ack = 0. restart beats a simultaneous hit_evt or cooldown expiry.
- rgb priority (highest first):
  1. Health bar: BAR_COLOR when BAR_Y ≤ vcount ≤ BAR_Y+7 and BAR_X ≤ hcount < BAR_X + 2*hp. hp = 0 draws no bar.
  2. Tank box in DEAD: DEAD_COLOR.
  3. Tank box in INVULN with counter[FLASH_BIT] = 1: FLASH_COLOR.
  4. Otherwise rgb.
- Tank box: xpos_t ≤ hcount < xpos_t+TANK_SIZE and ypos_t ≤ vcount < ypos_t+TANK_SIZE.
- Illegal state encoding → ALIVE, hp unchanged.

Optional Feature:
TANK_DMG_BULLET_DETECT_EN:
- Defined: bullet_overlap contributes to hit_evt (local geometric detection, covers a lost hit_in).
- Undefined: only the rising edge of hit_in counts; bullet ports are unused.

Test Plan:
1. Params DAMAGE=20, INVULN_CYCLES=16; reset, then pulse hit_in for 1 cycle → hit_ack 1 cycle, hp 100→80 two edges later, invuln high exactly 16 cycles, then ALIVE.
2. Hold hit_in high for 40 cycles, plus a second rising edge during cooldown → exactly one hp decrement (to 80).
3. Five spaced hits → hp 80,60,40,20,0; dead = 1 after the 5th, no invuln; a further hit_in leaves hp = 0.
4. hp = 10 with DAMAGE = 20, hit → hp saturates at 0, dead = 1. Then restart high coinciding with hit_in edge → hp = 100, state ALIVE, no hit_ack.
5. Feature on: tank at (100,200), bullet (120,230) → hit accepted. Bullet (0,0) or (148,230) → no hit. Feature off: (120,230) → no hit.
6. Pixel check at hp = 40, BAR_X = 10: hcount 89, vcount 12 → rgb_out 12'h0F0 one cycle later; hcount 90 → input rgb. Tank pixel during INVULN with FLASH_BIT = 2 alternates FLASH_COLOR every 4 cycles.

Source files
------------

// File: rtl/tank_damage_ctrl.sv
// tank_damage_ctrl
// -----------------------------------------------------------------------------
// Receiving end of the gun/hit path. Tracks our tank's health, applies a
// post-hit invulnerability cooldown, latches death, and overlays a health bar
// and a hit-flash onto the VGA stream (one stage in the VGA chain after the
// gun stage).
//
// Optional feature macro: TANK_DMG_BULLET_DETECT_EN
//   defined   : an opponent bullet inside our hitbox also counts as a hit
//   undefined : only a rising edge of hit_in counts; bullet ports are unused
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   restart                  level, return to full health
//   hit_in                   hit report from opponent gun (rising edge = hit)
//   xpos_bullet_op/ypos_...  opponent bullet position, (0,0) = no bullet
//   xpos_t, ypos_t           our tank top-left corner
//   hblnk..rgb               incoming VGA timing and pixel stream
//   *_out                    same stream delayed by exactly one cycle
//   hp                       current health
//   dead                     high while dead
//   hit_ack                  one-cycle pulse per accepted hit
//   invuln                   high during the cooldown
//
// Status outputs (hp, dead, hit_ack, invuln) are registered copies of the
// internal state, so they trail the internal state by one clock: a hit_in
// edge first sampled at edge N enters HIT at edge N and shows on the status
// outputs at edge N+2.
// -----------------------------------------------------------------------------
module tank_damage_ctrl #(
   parameter int          HP_MAX        = 100,
   parameter int          DAMAGE        = 20,
   parameter int          INVULN_CYCLES = 65000000,
   parameter int          FLASH_BIT     = 22,
   parameter int          BAR_X         = 10,
   parameter int          BAR_Y         = 10,
   parameter int          TANK_SIZE     = 48,
   parameter logic [11:0] FLASH_COLOR   = 12'hF00,
   parameter logic [11:0] DEAD_COLOR    = 12'h444,
   parameter logic [11:0] BAR_COLOR     = 12'h0F0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        restart,
   input  logic        hit_in,
   input  logic [9:0]  xpos_bullet_op,
   input  logic [9:0]  ypos_bullet_op,
   input  logic [9:0]  xpos_t,
   input  logic [9:0]  ypos_t,
   input  logic        hblnk,
   input  logic        vblnk,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [11:0] rgb,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic [11:0] rgb_out,
   output logic [6:0]  hp,
   output logic        dead,
   output logic        hit_ack,
   output logic        invuln
);

   // Counter must hold INVULN_CYCLES-1 and also contain the flash bit.
   localparam int CNT_W = ($clog2(INVULN_CYCLES) > FLASH_BIT) ?
                          $clog2(INVULN_CYCLES) : (FLASH_BIT + 1);

   localparam logic [6:0]       HP_FULL  = 7'(HP_MAX);
   localparam logic [6:0]       DMG      = 7'(DAMAGE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INVULN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [10:0]      BAR_X_W  = 11'(BAR_X);
   localparam logic [9:0]       BAR_Y_W  = 10'(BAR_Y);
   localparam logic [10:0]      TANK_W   = 11'(TANK_SIZE);

   typedef enum logic [1:0] {
      ALIVE  = 2'b00,
      HIT    = 2'b01,
      INVULN = 2'b10,
      DEAD   = 2'b11
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [6:0]       hp_r, hp_nxt_s, hp_dec_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             hit_in_q_r;
   logic             hit_evt_s;
   logic             in_bar_s, in_box_s;
   logic [10:0]      bar_x_end_s, tank_x_s, tank_y_s, vcount_w_s;
   logic [11:0]      rgb_nxt_s;

`ifdef TANK_DMG_BULLET_DETECT_EN
   logic        overlap_s;
   logic [10:0] bullet_x_s, bullet_y_s;

   // Local geometric hit detection: bullet anywhere inside our hitbox.
   always_comb begin
      bullet_x_s = {1'b0, xpos_bullet_op};
      bullet_y_s = {1'b0, ypos_bullet_op};
      overlap_s  = 1'b0;
      if (((xpos_bullet_op != 10'd0) || (ypos_bullet_op != 10'd0)) &&
          (bullet_x_s >= tank_x_s) && (bullet_x_s <= tank_x_s + TANK_W - 11'd1) &&
          (bullet_y_s >= tank_y_s) && (bullet_y_s <= tank_y_s + TANK_W - 11'd1)) begin
         overlap_s = 1'b1;
      end else begin
         overlap_s = 1'b0;
      end
      hit_evt_s = (hit_in & ~hit_in_q_r) | overlap_s;
   end
`else
   logic unused_bullet_s;
   assign unused_bullet_s = ^{xpos_bullet_op, ypos_bullet_op};

   // Only a rising edge of the opponent's hit report counts as a hit.
   always_comb begin
      hit_evt_s = hit_in & ~hit_in_q_r;
   end
`endif

   // Geometry in 11 bits so tank position + size never wraps.
   always_comb begin
      tank_x_s    = {1'b0, xpos_t};
      tank_y_s    = {1'b0, ypos_t};
      vcount_w_s  = {1'b0, vcount};
      bar_x_end_s = BAR_X_W + {3'b000, hp_r, 1'b0};
   end

   // State, health, cooldown counter and hit edge detector registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ALIVE;
         hp_r       <= HP_FULL;
         cnt_r      <= CNT_ZERO;
         hit_in_q_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         hp_r       <= hp_nxt_s;
         cnt_r      <= cnt_nxt_s;
         hit_in_q_r <= hit_in;
      end
   end

   // Next-state logic; restart overrides everything including a pending hit.
   always_comb begin
      state_nxt_s = state_r;
      hp_nxt_s    = hp_r;
      cnt_nxt_s   = cnt_r;
      hp_dec_s    = (hp_r <= DMG) ? 7'd0 : (hp_r - DMG);
      if (restart) begin
         state_nxt_s = ALIVE;
         hp_nxt_s    = HP_FULL;
         cnt_nxt_s   = CNT_ZERO;
      end else begin
         case (state_r)
            ALIVE: begin
               if (hit_evt_s) begin
                  state_nxt_s = HIT;
               end else begin
                  state_nxt_s = ALIVE;
               end
            end
            HIT: begin
               hp_nxt_s = hp_dec_s;
               if (hp_dec_s == 7'd0) begin
                  state_nxt_s = DEAD;
               end else begin
                  state_nxt_s = INVULN;
                  cnt_nxt_s   = CNT_ZERO;
               end
            end
            INVULN: begin
               // Hits during the cooldown are dropped, not queued.
               if (cnt_r == CNT_LAST) begin
                  state_nxt_s = ALIVE;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end
            DEAD: begin
               state_nxt_s = DEAD;
            end
            default: begin
               state_nxt_s = ALIVE;
            end
         endcase
      end
   end

   // Pixel overlay: bar over dead box over flash box over the incoming pixel.
   always_comb begin
      in_bar_s = (vcount >= BAR_Y_W) && (vcount <= BAR_Y_W + 10'd7) &&
                 (hcount >= BAR_X_W) && (hcount < bar_x_end_s);
      in_box_s = (hcount >= tank_x_s) && (hcount < tank_x_s + TANK_W) &&
                 (vcount_w_s >= tank_y_s) && (vcount_w_s < tank_y_s + TANK_W);
      if (in_bar_s) begin
         rgb_nxt_s = BAR_COLOR;
      end else if (in_box_s && (state_r == DEAD)) begin
         rgb_nxt_s = DEAD_COLOR;
      end else if (in_box_s && (state_r == INVULN) && cnt_r[FLASH_BIT]) begin
         rgb_nxt_s = FLASH_COLOR;
      end else begin
         rgb_nxt_s = rgb;
      end
   end

   // Registered VGA stream and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hcount_out <= 11'd0;
         vcount_out <= 10'd0;
         rgb_out    <= 12'h000;
         hp         <= HP_FULL;
         dead       <= 1'b0;
         hit_ack    <= 1'b0;
         invuln     <= 1'b0;
      end else begin
         hblnk_out  <= hblnk;
         vblnk_out  <= vblnk;
         hsync_out  <= hsync;
         vsync_out  <= vsync;
         hcount_out <= hcount;
         vcount_out <= vcount;
         rgb_out    <= rgb_nxt_s;
         hp         <= hp_r;
         dead       <= (state_r == DEAD);
         hit_ack    <= (state_r == HIT) && !restart;
         invuln     <= (state_r == INVULN);
      end
   end

endmodule

// File: tb/tb_tank_damage_ctrl.sv
// tb_tank_damage_ctrl
// Directed scenarios followed by randomized stimulus, all outputs compared
// every cycle against a behavioural model of health / cooldown / overlay.
// The model tracks a remaining-cooldown countdown and a pending-hit flag.
module tb_tank_damage_ctrl;

   localparam int HPM = 100;
   localparam int DMG = 20;
   localparam int INV = 16;
   localparam int FB  = 2;
   localparam int TS  = 48;

   logic        clk = 1'b0;
   logic        rst, restart, hit_in;
   logic [9:0]  xpos_bullet_op, ypos_bullet_op, xpos_t, ypos_t;
   logic        hblnk, vblnk, hsync, vsync;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [11:0] rgb;
   logic        hblnk_out, vblnk_out, hsync_out, vsync_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic [11:0] rgb_out;
   logic [6:0]  hp;
   logic        dead, hit_ack, invuln;

   // model state and expected outputs
   int          hp_m, cool_m;
   bit          pend_m, dead_m, prev_hit_m;
   logic        e_hblnk, e_vblnk, e_hsync, e_vsync, e_dead, e_ack, e_inv;
   logic [10:0] e_hcount;
   logic [9:0]  e_vcount;
   logic [11:0] e_rgb;
   int          e_hp;

   int n_total = 0;
   int n_bad   = 0;
   int exp_hp5;

   always #5 clk = ~clk;

   tank_damage_ctrl #(
      .DAMAGE(DMG), .INVULN_CYCLES(INV), .FLASH_BIT(FB)
   ) dut (
      .clk(clk), .rst(rst), .restart(restart), .hit_in(hit_in),
      .xpos_bullet_op(xpos_bullet_op), .ypos_bullet_op(ypos_bullet_op),
      .xpos_t(xpos_t), .ypos_t(ypos_t),
      .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
      .hcount(hcount), .vcount(vcount), .rgb(rgb),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out),
      .vsync_out(vsync_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
      .rgb_out(rgb_out), .hp(hp), .dead(dead), .hit_ack(hit_ack), .invuln(invuln)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Called right at the active edge: inputs still hold what the DUT sampled.
   task automatic model_edge();
      bit in_bar, in_box, evt;
      int elapsed;
      if (rst) begin
         {e_hblnk, e_vblnk, e_hsync, e_vsync, e_dead, e_ack, e_inv} = 7'b0;
         e_hcount = 11'd0; e_vcount = 10'd0; e_rgb = 12'h000; e_hp = HPM;
         hp_m = HPM; cool_m = 0; pend_m = 1'b0; dead_m = 1'b0; prev_hit_m = 1'b0;
      end else begin
         e_hblnk = hblnk; e_vblnk = vblnk; e_hsync = hsync; e_vsync = vsync;
         e_hcount = hcount; e_vcount = vcount;
         e_hp = hp_m; e_dead = dead_m; e_inv = (cool_m > 0); e_ack = pend_m && !restart;
         in_bar = (vcount >= 10) && (vcount <= 17) && (hcount >= 10) && (int'(hcount) < 10 + 2 * hp_m);
         in_box = (int'(hcount) >= int'(xpos_t)) && (int'(hcount) < int'(xpos_t) + TS) &&
                  (int'(vcount) >= int'(ypos_t)) && (int'(vcount) < int'(ypos_t) + TS);
         elapsed = INV - cool_m;
         if (in_bar) e_rgb = 12'h0F0;
         else if (in_box && dead_m) e_rgb = 12'h444;
         else if (in_box && cool_m > 0 && ((elapsed >> FB) % 2 == 1)) e_rgb = 12'hF00;
         else e_rgb = rgb;
         evt = hit_in && !prev_hit_m;
`ifdef TANK_DMG_BULLET_DETECT_EN
         if (!(xpos_bullet_op == 10'd0 && ypos_bullet_op == 10'd0) &&
             int'(xpos_bullet_op) >= int'(xpos_t) && int'(xpos_bullet_op) < int'(xpos_t) + TS &&
             int'(ypos_bullet_op) >= int'(ypos_t) && int'(ypos_bullet_op) < int'(ypos_t) + TS)
            evt = 1'b1;
`endif
         if (restart) begin
            hp_m = HPM; cool_m = 0; pend_m = 1'b0; dead_m = 1'b0;
         end else if (pend_m) begin
            pend_m = 1'b0;
            hp_m = (hp_m > DMG) ? hp_m - DMG : 0;
            if (hp_m == 0) dead_m = 1'b1;
            else cool_m = INV;
         end else if (cool_m > 0) begin
            cool_m--;
         end else if (!dead_m && evt) begin
            pend_m = 1'b1;
         end
         prev_hit_m = hit_in;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_val("hblnk_out", 32'(hblnk_out), 32'(e_hblnk));
      check_val("vblnk_out", 32'(vblnk_out), 32'(e_vblnk));
      check_val("hsync_out", 32'(hsync_out), 32'(e_hsync));
      check_val("vsync_out", 32'(vsync_out), 32'(e_vsync));
      check_val("hcount_out", 32'(hcount_out), 32'(e_hcount));
      check_val("vcount_out", 32'(vcount_out), 32'(e_vcount));
      check_val("rgb_out", 32'(rgb_out), 32'(e_rgb));
      check_val("hp", 32'(hp), 32'(e_hp));
      check_val("dead", 32'(dead), 32'(e_dead));
      check_val("hit_ack", 32'(hit_ack), 32'(e_ack));
      check_val("invuln", 32'(invuln), 32'(e_inv));
   endtask

   task automatic idle(input int n);
      hit_in = 1'b0;
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic pulse_hit();
      hit_in = 1'b1;
      cyc();
      hit_in = 1'b0;
      cyc();
   endtask

   task automatic do_restart();
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      cyc();
   endtask

   initial begin
      rst = 1'b1; restart = 1'b0; hit_in = 1'b0;
      xpos_bullet_op = 10'd0; ypos_bullet_op = 10'd0;
      xpos_t = 10'd100; ypos_t = 10'd200;
      hblnk = 1'b1; vblnk = 1'b1; hsync = 1'b1; vsync = 1'b1;
      hcount = 11'd5; vcount = 10'd5; rgb = 12'hABC;
      for (int k = 0; k < 3; k++) cyc();
      check_val("reset_hp", 32'(hp), 32'd100);
      check_val("reset_rgb", 32'(rgb_out), 32'h0);
      check_val("reset_hcount", 32'(hcount_out), 32'h0);
      rst = 1'b0;
      hblnk = 1'b0; vblnk = 1'b0; hsync = 1'b0; vsync = 1'b0;
      hcount = 11'd300; vcount = 10'd100; rgb = 12'h321;
      idle(2);

      // single pulse
      pulse_hit();
      idle(20);
      check_val("single_hit_hp", 32'(hp), 32'd80);

      // held hit plus a second edge inside the cooldown
      do_restart();
      hit_in = 1'b1; cyc(); cyc(); cyc();
      hit_in = 1'b0; cyc();
      hit_in = 1'b1;
      for (int k = 0; k < 40; k++) cyc();
      idle(5);
      check_val("held_hit_hp", 32'(hp), 32'd80);

      // five hits to death, then a further hit
      do_restart();
      for (int h = 0; h < 5; h++) begin
         pulse_hit();
         idle(20);
      end
      check_val("dead_hp", 32'(hp), 32'd0);
      check_val("dead_flag", 32'(dead), 32'd1);
      check_val("dead_invuln", 32'(invuln), 32'd0);
      pulse_hit();
      idle(5);
      check_val("dead_extra_hp", 32'(hp), 32'd0);

      // restart together with a rising hit edge
      restart = 1'b1; hit_in = 1'b1;
      cyc();
      restart = 1'b0;
      for (int k = 0; k < 5; k++) cyc();
      idle(3);
      check_val("restart_hp", 32'(hp), 32'd100);
      check_val("restart_dead", 32'(dead), 32'd0);

      // bullet geometry
      xpos_t = 10'd100; ypos_t = 10'd200;
      xpos_bullet_op = 10'd120; ypos_bullet_op = 10'd230;
      cyc();
      xpos_bullet_op = 10'd0; ypos_bullet_op = 10'd0;
      idle(4);
`ifdef TANK_DMG_BULLET_DETECT_EN
      exp_hp5 = 80;
`else
      exp_hp5 = 100;
`endif
      check_val("bullet_in_hp", 32'(hp), 32'(exp_hp5));
      idle(20);
      xpos_bullet_op = 10'd148; ypos_bullet_op = 10'd230;
      cyc();
      xpos_bullet_op = 10'd0; ypos_bullet_op = 10'd0;
      idle(4);
      check_val("bullet_out_hp", 32'(hp), 32'(exp_hp5));

      // health bar edge at hp = 40
      do_restart();
      for (int h = 0; h < 3; h++) begin
         pulse_hit();
         idle(20);
      end
      hcount = 11'd89; vcount = 10'd12; rgb = 12'h123;
      cyc();
      check_val("bar_last_px", 32'(rgb_out), 32'h0F0);
      hcount = 11'd90;
      cyc();
      check_val("bar_past_end", 32'(rgb_out), 32'h123);
      // flash inside the tank box during cooldown
      hcount = 11'd110; vcount = 10'd210; rgb = 12'h00A;
      pulse_hit();
      idle(20);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) hit_in = ~hit_in;
         restart = ($urandom_range(0, 149) == 0);
         if (i % 250 == 0) begin
            case ($urandom_range(0, 2))
               0: begin xpos_t = 10'd100; ypos_t = 10'd200; end
               1: begin xpos_t = 10'd20;  ypos_t = 10'd8;   end
               default: begin xpos_t = 10'd0; ypos_t = 10'd14; end
            endcase
         end
         case ($urandom_range(0, 19))
            0: begin
               xpos_bullet_op = 10'(int'(xpos_t) + int'($urandom_range(0, 47)));
               ypos_bullet_op = 10'(int'(ypos_t) + int'($urandom_range(0, 47)));
            end
            1: begin
               xpos_bullet_op = 10'(int'(xpos_t) + TS);
               ypos_bullet_op = 10'(int'(ypos_t) + int'($urandom_range(0, 47)));
            end
            default: begin
               xpos_bullet_op = 10'd0; ypos_bullet_op = 10'd0;
            end
         endcase
         hcount = 11'($urandom_range(0, 180));
         if ($urandom_range(0, 1) == 1) vcount = 10'($urandom_range(5, 20));
         else vcount = 10'(int'(ypos_t) + int'($urandom_range(0, 50)) - 1);
         rgb = 12'($urandom);
         {hblnk, vblnk, hsync, vsync} = 4'($urandom);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
